instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline; consumer of the EX->IF redirect (pc_sel_EXIF/jump_addr_EXIF).
//  Owns the PC, issues one-outstanding fetches over a valid/ready imem port, fills the IF/ID register.
//  Supports hazard-unit stall and EX-redirect flush; stale in-flight fetches are drained, never delivered.
// PARAMETERS
//  XLEN      32            datapath/PC width
//  RESET_PC  32'h0000_0000 PC loaded on reset
//  NOP_INSTR 32'h0000_0013 addi x0,x0,0; placed in instr_IFID on reset/flush/bubble
// PORTS
//  clk             in   1     clock, all state on rising edge
//  reset           in   1     synchronous, active-low (0 = reset)
//  pc_sel_EXIF     in   1     EX redirect request (branch taken / jump)
//  jump_addr_EXIF  in   XLEN  EX redirect target
//  stall_IF        in   1     hazard unit: hold IF/ID contents
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     imem accepts request this cycle
//  imem_addr       out  XLEN  fetch address (word aligned)
//  imem_resp_valid in   1     response valid (no backpressure; exactly one per accepted request, >=1 cycle later)
//  imem_resp_data  in   32    fetched instruction
//  instr_IFID      out  32    IF/ID instruction
//  pc_IFID         out  XLEN  IF/ID pc of instr_IFID
//  pc_4_IFID       out  XLEN  IF/ID pc+4
//  valid_IFID      out  1     IF/ID holds a real instruction
// BEHAVIOUR
//  Reset (reset==0 at edge): pc<=RESET_PC, state<=S_REQ, buffer empty, valid_IFID<=0,
//   instr_IFID<=NOP_INSTR, pc_IFID<=0, pc_4_IFID<=0. Outputs are combinational from state:
//   imem_req_valid==0 while reset==0. Reset mid-fetch abandons it; imem must tolerate
//   a response after reset, and that response is ignored (state S_REQ).
//  States:
//   S_REQ  : imem_req_valid=1, imem_addr=pc. Accept (valid&&ready) -> latch req_pc=pc, go S_WAIT.
//   S_WAIT : await resp. On resp: if !stall_IF load IF/ID {resp_data, req_pc, req_pc+4, valid=1},
//            pc<=req_pc+4, go S_REQ; if stall_IF capture resp into buffer, go S_HOLD.
//   S_HOLD : buffer full. When stall_IF==0 move buffer to IF/ID (valid=1), pc<=req_pc+4, go S_REQ.
//   S_DRAIN: stale request outstanding; no request issued; on resp discard it, go S_REQ.
//  IF/ID update rule: stall_IF==1 -> hold all IF/ID regs (unless redirect). stall_IF==0 and
//   no instruction delivered this cycle -> valid_IFID<=0, instr_IFID<=NOP_INSTR (bubble);
//   pc_IFID/pc_4_IFID hold.
//  Redirect (pc_sel_EXIF==1) has priority over stall and delivery:
//   pc<={jump_addr_EXIF[XLEN-1:2],2'b00}; valid_IFID<=0, instr_IFID<=NOP_INSTR even if stalled.
//   S_REQ: if request accepted same cycle -> S_DRAIN; else stay S_REQ (new pc next cycle).
//   S_WAIT: resp same cycle -> discard, S_REQ; else -> S_DRAIN.
//   S_HOLD: drop buffer -> S_REQ.  S_DRAIN: resp same cycle -> S_REQ; else stay S_DRAIN.
//  Latency: request issue to IF/ID valid = imem latency + 1 edge; best-case throughput
//   1 instr / 2 cycles (single outstanding request by design).
//  Arithmetic: pc+4 computed modulo 2^XLEN (0xFFFF_FFFC+4 -> 0). At most one request
//   outstanding; imem_req_valid never asserted in S_WAIT/S_HOLD/S_DRAIN.
// TESTING
//  1 Reset release, imem ready=1, 1-cycle latency returning addr-tagged data -> fetch addrs 0,4,8;
//    valid_IFID pulses with pc_IFID 0,4,8, pc_4_IFID 4,8,C.
//  2 stall_IF=1 for 3 cycles while resp arrives -> IF/ID unchanged, no new imem_req_valid;
//    on release buffered instr appears next edge, then fetch resumes at req_pc+4.
//  3 pc_sel_EXIF=1, jump_addr=0x100 in S_WAIT, resp 2 cycles later -> that resp discarded,
//    valid_IFID=0, next imem_addr=0x100, pc_IFID=0x100 delivered.
//  4 Redirect on same cycle as resp and as stall_IF=1 -> IF/ID flushed to NOP, valid=0; resp dropped.
//  5 jump_addr_EXIF=0x203 -> imem_addr=0x200; pc=0xFFFF_FFFC fetch -> pc_4_IFID=0, next addr 0.
//  6 reset=0 asserted in S_WAIT, resp arrives during/after reset -> ignored; first fetch addr RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I IF stage: PC owner, single-outstanding imem fetch, IF/ID register
module instruction_fetch #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_sel_EXIF,
  input  logic [XLEN-1:0] jump_addr_EXIF,
  input  logic            stall_IF,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     instr_IFID,
  output logic [XLEN-1:0] pc_IFID,
  output logic [XLEN-1:0] pc_4_IFID,
  output logic            valid_IFID
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_ifid_q, pc_ifid_d;
  logic [XLEN-1:0] pc_4_ifid_q, pc_4_ifid_d;
  logic            valid_q, valid_d;

  logic            req_accept;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] next_seq_pc;
  logic            unused_jump_lsbs;

  // Request is a pure function of state so reset can silence it immediately.
  assign imem_req_valid   = (state_q == S_REQ) && reset;
  assign imem_addr        = pc_q;
  assign req_accept       = imem_req_valid && imem_req_ready;
  assign redirect_pc      = {jump_addr_EXIF[XLEN-1:2], 2'b00};
  assign next_seq_pc      = req_pc_q + PC_STEP;
  assign unused_jump_lsbs = ^jump_addr_EXIF[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    buf_d         = buf_q;
    instr_d       = instr_q;
    pc_ifid_d     = pc_ifid_q;
    pc_4_ifid_d   = pc_4_ifid_q;
    valid_d       = valid_q;
    deliver       = 1'b0;
    deliver_instr = buf_q;

    case (state_q)
      S_REQ: begin
        if (req_accept) begin
          req_pc_d = pc_q;
          state_d  = pc_sel_EXIF ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (pc_sel_EXIF) begin
          state_d = imem_resp_valid ? S_REQ : S_DRAIN;
        end else if (imem_resp_valid) begin
          if (stall_IF) begin
            buf_d   = imem_resp_data;
            state_d = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_resp_data;
            pc_d          = next_seq_pc;
            state_d       = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (pc_sel_EXIF) begin
          state_d = S_REQ;
        end else if (!stall_IF) begin
          deliver       = 1'b1;
          deliver_instr = buf_q;
          pc_d          = next_seq_pc;
          state_d       = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response is swallowed here; the redirect pc is already loaded.
        if (imem_resp_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (pc_sel_EXIF) begin
      pc_d = redirect_pc;
    end

    // Flush beats stall; an unstalled cycle without delivery inserts a bubble.
    if (pc_sel_EXIF) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall_IF) begin
      if (deliver) begin
        valid_d     = 1'b1;
        instr_d     = deliver_instr;
        pc_ifid_d   = req_pc_q;
        pc_4_ifid_d = next_seq_pc;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      buf_q       <= 32'h0;
      instr_q     <= NOP_INSTR;
      pc_ifid_q   <= {XLEN{1'b0}};
      pc_4_ifid_q <= {XLEN{1'b0}};
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_q       <= buf_d;
      instr_q     <= instr_d;
      pc_ifid_q   <= pc_ifid_d;
      pc_4_ifid_q <= pc_4_ifid_d;
      valid_q     <= valid_d;
    end
  end

  assign instr_IFID = instr_q;
  assign pc_IFID    = pc_ifid_q;
  assign pc_4_IFID  = pc_4_ifid_q;
  assign valid_IFID = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch with an imem responder
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        pc_sel_EXIF;
  logic [31:0] jump_addr_EXIF;
  logic        stall_IF;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr_IFID;
  logic [31:0] pc_IFID;
  logic [31:0] pc_4_IFID;
  logic        valid_IFID;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .pc_sel_EXIF    (pc_sel_EXIF),
    .jump_addr_EXIF (jump_addr_EXIF),
    .stall_IF       (stall_IF),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_IFID     (instr_IFID),
    .pc_IFID        (pc_IFID),
    .pc_4_IFID      (pc_4_IFID),
    .valid_IFID     (valid_IFID)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // imem responder: one reply per accepted request, lat_lo..lat_hi cycles later
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          rdy_mode = 0;
  logic        acc_plan;
  logic [31:0] addr_plan;
  logic [31:0] paddr;
  bit          pend;
  int          cnt;

  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    acc_plan = 1'b0; addr_plan = 32'h0; paddr = 32'h0; pend = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (acc_plan) begin
        n_checks++;
        if (pend) begin
          n_fail++;
          $display("FAIL one_outstanding: request for %h accepted while reply for %h still owed", addr_plan, paddr);
        end
        pend  = 1'b1;
        cnt   = $urandom_range(lat_lo, lat_hi);
        paddr = addr_plan;
      end
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = imem_word(paddr);
          pend = 1'b0;
        end
      end
      case (rdy_mode)
        0:       imem_req_ready = 1'b1;
        1:       imem_req_ready = ($urandom_range(0, 1) == 1);
        default: imem_req_ready = 1'b0;
      endcase
      acc_plan  = imem_req_valid && imem_req_ready;
      addr_plan = imem_addr;
    end
  end

  logic        pre_acc, pre_req_valid;
  logic [31:0] pre_addr;
  logic        old_valid;
  logic [31:0] old_instr, old_pc, old_pc4;

  // Called at a negedge: drive inputs, sample pre-edge view, return at next negedge.
  task automatic cycle(input logic st, input logic ps, input logic [31:0] ja);
    stall_IF       = st;
    pc_sel_EXIF    = ps;
    jump_addr_EXIF = ja;
    old_valid = valid_IFID; old_instr = instr_IFID; old_pc = pc_IFID; old_pc4 = pc_4_IFID;
    #3;
    pre_req_valid = imem_req_valid;
    pre_acc       = imem_req_valid && imem_req_ready;
    pre_addr      = imem_addr;
    @(negedge clk);
  endtask

  task automatic wait_delivery(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16 && !ok; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (valid_IFID) ok = 1'b1;
    end
  endtask

  task automatic wait_accept(output bit ok, output logic [31:0] a);
    ok = 1'b0;
    a  = 32'h0;
    for (int k = 0; k < 16 && !ok; k++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (pre_acc) begin ok = 1'b1; a = pre_addr; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (pre_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_req_valid: got %b want 0", pre_req_valid);
      end
    end
    n_checks++;
    if ({valid_IFID, instr_IFID, pc_IFID, pc_4_IFID} !== {1'b0, NOP, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_ifid: got v=%b i=%h pc=%h pc4=%h want v=0 i=%h pc=0 pc4=0",
               valid_IFID, instr_IFID, pc_IFID, pc_4_IFID, NOP);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] p;
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (i % 2 == 1) begin
        p = 32'((i - 1) / 2 * 4);
        if ({pre_acc, pre_addr} !== {1'b1, p}) begin
          n_fail++; $display("FAIL fetch_addr[%0d]: got acc=%b addr=%h want acc=1 addr=%h", i, pre_acc, pre_addr, p);
        end
        n_checks++;
        if ({valid_IFID, instr_IFID} !== {1'b0, NOP}) begin
          n_fail++; $display("FAIL fetch_bubble[%0d]: got v=%b i=%h want v=0 i=%h", i, valid_IFID, instr_IFID, NOP);
        end
      end else begin
        p = 32'((i / 2 - 1) * 4);
        if (pre_req_valid !== 1'b0) begin
          n_fail++; $display("FAIL fetch_noreq[%0d]: got req_valid=%b want 0", i, pre_req_valid);
        end
        n_checks++;
        if ({valid_IFID, pc_IFID, pc_4_IFID, instr_IFID} !== {1'b1, p, p + 32'd4, imem_word(p)}) begin
          n_fail++;
          $display("FAIL fetch_deliver[%0d]: got v=%b pc=%h pc4=%h i=%h want v=1 pc=%h pc4=%h i=%h",
                   i, valid_IFID, pc_IFID, pc_4_IFID, instr_IFID, p, p + 32'd4, imem_word(p));
        end
      end
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({pre_acc, pre_addr} !== {1'b1, 32'hC}) begin
      n_fail++; $display("FAIL stall_req: got acc=%b addr=%h want acc=1 addr=c", pre_acc, pre_addr);
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle(1'b1, 1'b0, 32'h0);
      n_checks++;
      if (i > 0 && pre_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_noreq[%0d]: got req_valid=1 want 0", i);
      end
      n_checks++;
      if ({valid_IFID, pc_IFID, pc_4_IFID, instr_IFID} !== {1'b1, 32'h8, 32'hC, imem_word(32'h8)}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h pc4=%h i=%h want v=1 pc=8 pc4=c i=%h",
                 i, valid_IFID, pc_IFID, pc_4_IFID, instr_IFID, imem_word(32'h8));
      end
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({valid_IFID, pc_IFID, pc_4_IFID, instr_IFID} !== {1'b1, 32'hC, 32'h10, imem_word(32'hC)}) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b pc=%h pc4=%h i=%h want v=1 pc=c pc4=10 i=%h",
               valid_IFID, pc_IFID, pc_4_IFID, instr_IFID, imem_word(32'hC));
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({pre_acc, pre_addr, valid_IFID, instr_IFID, pc_IFID} !== {1'b1, 32'h10, 1'b0, NOP, 32'hC}) begin
      n_fail++;
      $display("FAIL stall_resume: got acc=%b addr=%h v=%b i=%h pc=%h want acc=1 addr=10 v=0 i=%h pc=c",
               pre_acc, pre_addr, valid_IFID, instr_IFID, pc_IFID, NOP);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({valid_IFID, pc_IFID, instr_IFID} !== {1'b1, 32'h10, imem_word(32'h10)}) begin
      n_fail++; $display("FAIL stall_next: got v=%b pc=%h i=%h want v=1 pc=10", valid_IFID, pc_IFID, instr_IFID);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    lat_lo = 2; lat_hi = 2;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h100);
    n_checks++;
    if ({valid_IFID, instr_IFID} !== {1'b0, NOP}) begin
      n_fail++; $display("FAIL redir_flush: got v=%b i=%h want v=0 i=%h", valid_IFID, instr_IFID, NOP);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({pre_req_valid, valid_IFID} !== 2'b00) begin
      n_fail++; $display("FAIL redir_drain: got req_valid=%b v=%b want 0 0", pre_req_valid, valid_IFID);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({pre_acc, pre_addr} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL redir_addr: got acc=%b addr=%h want acc=1 addr=100", pre_acc, pre_addr);
    end
    wait_delivery(ok);
    n_checks++;
    if (!ok || {pc_IFID, pc_4_IFID, instr_IFID} !== {32'h100, 32'h104, imem_word(32'h100)}) begin
      n_fail++; $display("FAIL redir_deliver: got ok=%b pc=%h pc4=%h i=%h want pc=100 pc4=104", ok, pc_IFID, pc_4_IFID, instr_IFID);
    end
    lat_lo = 1; lat_hi = 1;
  endtask

  task automatic test_redirect_stall();
    bit ok;
    cycle(1'b1, 1'b0, 32'h0);
    n_checks++;
    if ({pre_acc, pre_addr} !== {1'b1, 32'h104}) begin
      n_fail++; $display("FAIL rs_req: got acc=%b addr=%h want acc=1 addr=104", pre_acc, pre_addr);
    end
    cycle(1'b1, 1'b1, 32'h40);
    n_checks++;
    if ({valid_IFID, instr_IFID, pc_IFID, pc_4_IFID} !== {1'b0, NOP, 32'h100, 32'h104}) begin
      n_fail++;
      $display("FAIL rs_flush: got v=%b i=%h pc=%h pc4=%h want v=0 i=%h pc=100 pc4=104",
               valid_IFID, instr_IFID, pc_IFID, pc_4_IFID, NOP);
    end
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if ({pre_acc, pre_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL rs_addr: got acc=%b addr=%h want acc=1 addr=40", pre_acc, pre_addr);
    end
    wait_delivery(ok);
    n_checks++;
    if (!ok || {pc_IFID, instr_IFID} !== {32'h40, imem_word(32'h40)}) begin
      n_fail++; $display("FAIL rs_deliver: got ok=%b pc=%h i=%h want pc=40 i=%h", ok, pc_IFID, instr_IFID, imem_word(32'h40));
    end
  endtask

  task automatic test_align_wrap();
    bit ok;
    logic [31:0] a;
    cycle(1'b0, 1'b1, 32'h203);
    wait_accept(ok, a);
    n_checks++;
    if (!ok || a !== 32'h200) begin
      n_fail++; $display("FAIL align_addr: got ok=%b addr=%h want addr=200", ok, a);
    end
    wait_delivery(ok);
    n_checks++;
    if (!ok || {pc_IFID, pc_4_IFID, instr_IFID} !== {32'h200, 32'h204, imem_word(32'h200)}) begin
      n_fail++; $display("FAIL align_deliver: got ok=%b pc=%h pc4=%h i=%h want pc=200 pc4=204", ok, pc_IFID, pc_4_IFID, instr_IFID);
    end
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    wait_accept(ok, a);
    n_checks++;
    if (!ok || a !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_addr: got ok=%b addr=%h want addr=fffffffc", ok, a);
    end
    wait_delivery(ok);
    n_checks++;
    if (!ok || {pc_IFID, pc_4_IFID, instr_IFID} !== {32'hFFFF_FFFC, 32'h0, imem_word(32'hFFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap_deliver: got ok=%b pc=%h pc4=%h i=%h want pc=fffffffc pc4=0", ok, pc_IFID, pc_4_IFID, instr_IFID);
    end
    wait_accept(ok, a);
    n_checks++;
    if (!ok || a !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: got ok=%b addr=%h want addr=0", ok, a);
    end
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    logic [31:0] a;
    lat_lo = 3; lat_hi = 3;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      n_checks++;
      if (pre_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_req[%0d]: got req_valid=1 want 0", i);
      end
    end
    n_checks++;
    if ({valid_IFID, instr_IFID, pc_IFID, pc_4_IFID} !== {1'b0, NOP, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL mid_reset_ifid: got v=%b i=%h pc=%h pc4=%h want v=0 i=%h pc=0 pc4=0",
               valid_IFID, instr_IFID, pc_IFID, pc_4_IFID, NOP);
    end
    reset = 1'b1;
    rdy_mode = 2;
    lat_lo = 1; lat_hi = 1;
    cycle(1'b0, 1'b0, 32'h0);
    n_checks++;
    if (valid_IFID !== 1'b0) begin
      n_fail++; $display("FAIL mid_stale_resp: got v=%b pc=%h want v=0", valid_IFID, pc_IFID);
    end
    rdy_mode = 0;
    wait_accept(ok, a);
    n_checks++;
    if (!ok || a !== 32'h0) begin
      n_fail++; $display("FAIL mid_first_addr: got ok=%b addr=%h want addr=0", ok, a);
    end
    wait_delivery(ok);
    n_checks++;
    if (!ok || {pc_IFID, pc_4_IFID, instr_IFID} !== {32'h0, 32'h4, imem_word(32'h0)}) begin
      n_fail++; $display("FAIL mid_deliver: got ok=%b pc=%h pc4=%h i=%h want pc=0 pc4=4", ok, pc_IFID, pc_4_IFID, instr_IFID);
    end
  endtask

  // Random traffic against an in-order program-counter model.
  task automatic test_random();
    logic [31:0] exp_pc, ja;
    logic        st, ps;
    int          deliveries;
    reset = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    exp_pc = 32'h0;
    deliveries = 0;
    rdy_mode = 1; lat_lo = 1; lat_hi = 3;
    for (int n = 0; n < 600; n++) begin
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 15) == 0);
      ja = $urandom;
      cycle(st, ps, ja);
      if (pre_acc && !ps) begin
        n_checks++;
        if (pre_addr !== exp_pc) begin
          n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, pre_addr, exp_pc);
        end
      end
      n_checks++;
      if (ps) begin
        if ({valid_IFID, instr_IFID, pc_IFID, pc_4_IFID} !== {1'b0, NOP, old_pc, old_pc4}) begin
          n_fail++; $display("FAIL rnd_flush[%0d]: got v=%b i=%h pc=%h want v=0 pc=%h", n, valid_IFID, instr_IFID, pc_IFID, old_pc);
        end
        exp_pc = {ja[31:2], 2'b00};
      end else if (st) begin
        if ({valid_IFID, instr_IFID, pc_IFID, pc_4_IFID} !== {old_valid, old_instr, old_pc, old_pc4}) begin
          n_fail++; $display("FAIL rnd_hold[%0d]: got v=%b i=%h pc=%h want v=%b i=%h pc=%h",
                             n, valid_IFID, instr_IFID, pc_IFID, old_valid, old_instr, old_pc);
        end
      end else if (valid_IFID) begin
        if ({instr_IFID, pc_IFID, pc_4_IFID} !== {imem_word(exp_pc), exp_pc, exp_pc + 32'd4}) begin
          n_fail++; $display("FAIL rnd_deliver[%0d]: got pc=%h pc4=%h i=%h want pc=%h i=%h",
                             n, pc_IFID, pc_4_IFID, instr_IFID, exp_pc, imem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end else begin
        if ({instr_IFID, pc_IFID, pc_4_IFID} !== {NOP, old_pc, old_pc4}) begin
          n_fail++; $display("FAIL rnd_bubble[%0d]: got i=%h pc=%h want i=%h pc=%h", n, instr_IFID, pc_IFID, NOP, old_pc);
        end
      end
    end
    n_checks++;
    if (deliveries < 30) begin
      n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >= 30", deliveries);
    end
    rdy_mode = 0; lat_lo = 1; lat_hi = 1;
  endtask

  initial begin
    reset = 1'b0; stall_IF = 1'b0; pc_sel_EXIF = 1'b0; jump_addr_EXIF = 32'h0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_align_wrap();
    test_reset_midfetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
